// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with per-key debounce, one-entry key buffer and overrun flag.
// Define KEYPAD_COL_SYNC_EN to route cols through a 2-flop synchronizer (adds 2 cycles of latency).
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int BW = $clog2(DEB_CYCLES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_FULL   = BW'(DEB_CYCLES);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [3:0]    cols_s;
  logic [1:0]    state_r, state_nxt_s;
  logic [1:0]    row_r, row_nxt_s;
  logic [1:0]    col_r, col_nxt_s;
  logic [DW-1:0] dwell_r, dwell_nxt_s;
  logic [BW-1:0] deb_r, deb_nxt_s, deb_sat_s;
  logic          col_low_s, idle_s, emit_s, load_s, drop_s, pop_s, valid_nxt_s;

  // Lowest-index active-low column; only called when at least one column is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] v);
    logic [1:0] idx;
    if (!v[0]) begin
      idx = 2'd0;
    end else if (!v[1]) begin
      idx = 2'd1;
    end else if (!v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

`ifdef KEYPAD_COL_SYNC_EN
  logic [3:0] cols_meta_r, cols_sync_r;

  // Two-flop column synchronizer, idles at "no key".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cols_meta_r <= 4'hF;
      cols_sync_r <= 4'hF;
    end else begin
      cols_meta_r <= cols;
      cols_sync_r <= cols_meta_r;
    end
  end

  assign cols_s = cols_sync_r;
`else
  assign cols_s = cols;
`endif

  assign col_low_s = ~cols_s[col_r];
  assign idle_s    = (cols_s == 4'b1111);
  assign deb_sat_s = (deb_r < DEB_FULL) ? (deb_r + BW'(1)) : deb_r;

  // Scan / debounce / hold / release next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    dwell_nxt_s = dwell_r;
    deb_nxt_s   = deb_r;
    emit_s      = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (dwell_r >= DWELL_LAST) begin
          dwell_nxt_s = '0;
          if (idle_s) begin
            row_nxt_s = row_r + 2'd1;
          end else begin
            col_nxt_s   = lowest_low(cols_s);
            deb_nxt_s   = '0;
            state_nxt_s = ST_DEBOUNCE;
          end
        end else begin
          dwell_nxt_s = dwell_r + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (col_low_s) begin
          if (deb_sat_s == DEB_FULL) begin
            deb_nxt_s   = '0;
            emit_s      = 1'b1;
            state_nxt_s = ST_HOLD;
          end else begin
            deb_nxt_s = deb_sat_s;
          end
        end else begin
          // Bounce: retry the same row with a fresh dwell.
          deb_nxt_s   = '0;
          dwell_nxt_s = '0;
          state_nxt_s = ST_SCAN;
        end
      end
      ST_HOLD: begin
        if (!col_low_s) begin
          deb_nxt_s   = '0;
          state_nxt_s = ST_RELEASE;
        end else begin
          deb_nxt_s = '0;
        end
      end
      ST_RELEASE: begin
        if (idle_s) begin
          if (deb_sat_s == DEB_FULL) begin
            deb_nxt_s   = '0;
            dwell_nxt_s = '0;
            row_nxt_s   = row_r + 2'd1;
            state_nxt_s = ST_SCAN;
          end else begin
            deb_nxt_s = deb_sat_s;
          end
        end else begin
          deb_nxt_s   = '0;
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_SCAN;
        row_nxt_s   = 2'd0;
        dwell_nxt_s = '0;
        deb_nxt_s   = '0;
      end
    endcase
  end

  // One-entry key buffer: a pop in the same cycle frees room for the new code.
  always_comb begin
    pop_s  = key_valid & key_ready;
    load_s = emit_s & (~key_valid | key_ready);
    drop_s = emit_s & key_valid & ~key_ready;
    if (load_s) begin
      valid_nxt_s = 1'b1;
    end else if (pop_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = key_valid;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_SCAN;
      row_r     <= 2'd0;
      col_r     <= 2'd0;
      dwell_r   <= '0;
      deb_r     <= '0;
      rows      <= 4'b1110;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      row_r     <= row_nxt_s;
      col_r     <= col_nxt_s;
      dwell_r   <= dwell_nxt_s;
      deb_r     <= deb_nxt_s;
      rows      <= ~(4'b0001 << row_nxt_s);
      key       <= load_s ? {row_r, col_r} : key;
      key_valid <= valid_nxt_s;
      key_held  <= (state_nxt_s == ST_HOLD);
      overrun   <= drop_s;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl; a keypad model drives cols from rows and a pressed-key mask.
module tb_keypad_scan_ctrl;

`ifdef KEYPAD_COL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cols, rows, key;
  logic        key_valid, key_ready, key_held, overrun;
  logic [15:0] pressed = 16'h0000;
  logic        glitch_en = 1'b0;
  logic [3:0]  glitch_val = 4'b1111;
  logic [3:0]  exp_rows;
  int          vectors = 0;
  int          miscompares = 0;
  int          edge_n = 0;

  keypad_scan_ctrl dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows), .key(key),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    cols = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[4*r+c] && !rows[r]) cols[c] = 1'b0;
      end
    end
    if (glitch_en) cols = glitch_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int t);
    while (edge_n < t) tick();
  endtask

  task automatic do_reset(input logic kr);
    reset = 1'b0;
    pressed = 16'h0000;
    glitch_en = 1'b0;
    key_ready = kr;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    key_ready = 1'b0;
    reset = 1'b0;
    #100;
    vectors += 5;
    if (rows !== 4'b1110) begin $display("FAIL rst_rows: got %b expected 1110", rows); miscompares++; end
    if (key !== 4'h0) begin $display("FAIL rst_key: got %h expected 0", key); miscompares++; end
    if (key_valid !== 1'b0) begin $display("FAIL rst_valid: got %b expected 0", key_valid); miscompares++; end
    if (key_held !== 1'b0) begin $display("FAIL rst_held: got %b expected 0", key_held); miscompares++; end
    if (overrun !== 1'b0) begin $display("FAIL rst_overrun: got %b expected 0", overrun); miscompares++; end
    @(posedge clk);
    #1;
    reset = 1'b1;
    edge_n = 0;
    for (int n = 1; n <= 64; n++) begin
      tick();
      exp_rows = ~(4'b0001 << ((edge_n / 16) % 4));
      vectors += 2;
      if (rows !== exp_rows) begin
        $display("FAIL scan_rows@%0d: got %b expected %b", edge_n, rows, exp_rows); miscompares++;
      end
      if (key_valid !== 1'b0) begin
        $display("FAIL scan_valid@%0d: got %b expected 0", edge_n, key_valid); miscompares++;
      end
    end
  endtask

  task automatic test_press_release();
    int e;
    do_reset(1'b1);
    tick_to(32);
    vectors++;
    if (rows !== 4'b1011) begin $display("FAIL pr_row2: got %b expected 1011", rows); miscompares++; end
    pressed = 16'h0800;
    tick_to(48);
    vectors++;
    if (rows !== 4'b1011) begin $display("FAIL pr_deb_rows: got %b expected 1011", rows); miscompares++; end
    tick_to(111);
    vectors += 2;
    if (key_valid !== 1'b0) begin $display("FAIL pr_early_valid: got %b expected 0", key_valid); miscompares++; end
    if (key_held !== 1'b0) begin $display("FAIL pr_early_held: got %b expected 0", key_held); miscompares++; end
    tick_to(112);
    vectors += 3;
    if (key_valid !== 1'b1) begin $display("FAIL pr_valid: got %b expected 1", key_valid); miscompares++; end
    if (key !== 4'hB) begin $display("FAIL pr_key: got %h expected b", key); miscompares++; end
    if (key_held !== 1'b1) begin $display("FAIL pr_held: got %b expected 1", key_held); miscompares++; end
    tick_to(113);
    vectors++;
    if (key_valid !== 1'b0) begin $display("FAIL pr_pop: got %b expected 0", key_valid); miscompares++; end
    for (int i = 0; i < 50; i++) begin
      tick();
      vectors += 2;
      if (key_valid !== 1'b0) begin $display("FAIL pr_hold_valid@%0d: got %b expected 0", edge_n, key_valid); miscompares++; end
      if (key_held !== 1'b1) begin $display("FAIL pr_hold_held@%0d: got %b expected 1", edge_n, key_held); miscompares++; end
    end
    e = edge_n;
    pressed = 16'h0000;
    tick_to(e + SL);
    vectors++;
    if (key_held !== 1'b1) begin $display("FAIL pr_rel_held: got %b expected 1", key_held); miscompares++; end
    tick_to(e + 1 + SL);
    vectors++;
    if (key_held !== 1'b0) begin $display("FAIL pr_rel_drop: got %b expected 0", key_held); miscompares++; end
    tick_to(e + 64 + SL);
    vectors++;
    if (rows !== 4'b1011) begin $display("FAIL pr_rel_rows: got %b expected 1011", rows); miscompares++; end
    tick_to(e + 65 + SL);
    vectors += 2;
    if (rows !== 4'b0111) begin $display("FAIL pr_next_row: got %b expected 0111", rows); miscompares++; end
    if (key_valid !== 1'b0) begin $display("FAIL pr_no_reemit: got %b expected 0", key_valid); miscompares++; end
  endtask

  task automatic test_glitch();
    do_reset(1'b0);
    tick_to(10);
    glitch_val = 4'b1110;
    glitch_en = 1'b1;
    tick_to(20);
    glitch_en = 1'b0;
    while (edge_n < 36 + SL) begin
      tick();
      vectors++;
      if (key_valid !== 1'b0) begin $display("FAIL gl_valid@%0d: got %b expected 0", edge_n, key_valid); miscompares++; end
      if (edge_n == 16) begin
        vectors++;
        if (rows !== 4'b1110) begin $display("FAIL gl_row_hold: got %b expected 1110", rows); miscompares++; end
      end
    end
    vectors++;
    if (rows !== 4'b1110) begin $display("FAIL gl_redwell: got %b expected 1110", rows); miscompares++; end
    tick();
    vectors++;
    if (rows !== 4'b1101) begin $display("FAIL gl_advance: got %b expected 1101", rows); miscompares++; end
  endtask

  task automatic test_overrun();
    do_reset(1'b0);
    pressed = 16'h0002;
    tick_to(79);
    vectors++;
    if (key_valid !== 1'b0) begin $display("FAIL ov_early: got %b expected 0", key_valid); miscompares++; end
    tick_to(80);
    vectors += 3;
    if (key_valid !== 1'b1) begin $display("FAIL ov_valid1: got %b expected 1", key_valid); miscompares++; end
    if (key !== 4'h1) begin $display("FAIL ov_key1: got %h expected 1", key); miscompares++; end
    if (overrun !== 1'b0) begin $display("FAIL ov_first: got %b expected 0", overrun); miscompares++; end
    tick_to(90);
    pressed = 16'h0040;
    tick_to(155 + SL);
    vectors++;
    if (rows !== 4'b1101) begin $display("FAIL ov_row1: got %b expected 1101", rows); miscompares++; end
    tick_to(234 + SL);
    vectors += 2;
    if (overrun !== 1'b0) begin $display("FAIL ov_pre: got %b expected 0", overrun); miscompares++; end
    if (key_held !== 1'b0) begin $display("FAIL ov_pre_held: got %b expected 0", key_held); miscompares++; end
    tick_to(235 + SL);
    vectors += 4;
    if (overrun !== 1'b1) begin $display("FAIL ov_pulse: got %b expected 1", overrun); miscompares++; end
    if (key !== 4'h1) begin $display("FAIL ov_key_kept: got %h expected 1", key); miscompares++; end
    if (key_valid !== 1'b1) begin $display("FAIL ov_valid_kept: got %b expected 1", key_valid); miscompares++; end
    if (key_held !== 1'b1) begin $display("FAIL ov_held2: got %b expected 1", key_held); miscompares++; end
    tick_to(236 + SL);
    vectors++;
    if (overrun !== 1'b0) begin $display("FAIL ov_one_cycle: got %b expected 0", overrun); miscompares++; end
    tick_to(240 + SL);
    vectors++;
    if (key_valid !== 1'b1) begin $display("FAIL ov_wait: got %b expected 1", key_valid); miscompares++; end
    key_ready = 1'b1;
    tick();
    vectors++;
    if (key_valid !== 1'b0) begin $display("FAIL ov_drain: got %b expected 0", key_valid); miscompares++; end
  endtask

  task automatic test_multi_col_reset();
    do_reset(1'b0);
    pressed = 16'h0500;
    tick_to(48);
    vectors++;
    if (rows !== 4'b1011) begin $display("FAIL mc_rows: got %b expected 1011", rows); miscompares++; end
    tick_to(112);
    vectors += 3;
    if (key_valid !== 1'b1) begin $display("FAIL mc_valid: got %b expected 1", key_valid); miscompares++; end
    if (key !== 4'h8) begin $display("FAIL mc_key: got %h expected 8", key); miscompares++; end
    if (key_held !== 1'b1) begin $display("FAIL mc_held: got %b expected 1", key_held); miscompares++; end
    tick_to(115);
    reset = 1'b0;
    #1;
    vectors += 4;
    if (key_valid !== 1'b0) begin $display("FAIL hr_valid: got %b expected 0", key_valid); miscompares++; end
    if (rows !== 4'b1110) begin $display("FAIL hr_rows: got %b expected 1110", rows); miscompares++; end
    if (key_held !== 1'b0) begin $display("FAIL hr_held: got %b expected 0", key_held); miscompares++; end
    if (key !== 4'h0) begin $display("FAIL hr_key: got %h expected 0", key); miscompares++; end
    do_reset(1'b0);
    tick_to(20);
    vectors += 2;
    if (key_valid !== 1'b0) begin $display("FAIL hr_after_valid: got %b expected 0", key_valid); miscompares++; end
    if (rows !== 4'b1101) begin $display("FAIL hr_after_rows: got %b expected 1101", rows); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_overrun();
    test_multi_col_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clock cycles each row is driven before advancing (>=4).
REQ-002 SHALL have parameter DEB_CYCLES, default 64: consecutive stable samples required for press or release (>=2).
REQ-003 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cols, input, 4: keypad column sense, active-low (4'b1111 = no key).
REQ-006 SHALL have port rows, output, 4: keypad row drive, one-hot active-low.
REQ-007 SHALL have port key, output, 4: buffered key code = 4*row_index + col_index.
REQ-008 SHALL have port key_valid, output, 1: key buffer holds an unconsumed code.
REQ-009 SHALL have port key_ready, input, 1: consumer (main_fsm) accepts key when high with key_valid.
REQ-010 SHALL have port key_held, output, 1: high while a debounced press is held (HOLD state).
REQ-011 SHALL have port overrun, output, 1: one-cycle pulse when a debounced key is dropped because the buffer is full.

Function
REQ-012 SHALL implement states SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-013 SHALL drive rows = ~(4'b0001 << r), r = current row index 0..3.
REQ-014 SCAN: SHALL hold each row SCAN_DIV cycles; on the last dwell cycle, if sampled cols == 4'b1111, r advances mod 4 (3 wraps to 0); otherwise latch c and go DEBOUNCE with r held.
REQ-015 c SHALL be the lowest index with cols[c] == 0; multiple low columns resolve to the lowest index.
REQ-016 DEBOUNCE: SHALL count consecutive cycles with cols[c] == 0; count reaching DEB_CYCLES -> HOLD; any cycle with cols[c] == 1 -> SCAN, same r, dwell counter cleared.
REQ-017 On DEBOUNCE->HOLD transition, code {r[1:0], c[1:0]} SHALL load into the buffer when it is empty or is popped that same cycle; key_valid is high the following cycle.
REQ-018 If the buffer is full and not popped at that transition, the code SHALL be discarded, the buffer unchanged, and overrun pulses high for exactly one cycle.
REQ-019 HOLD: key_held = 1; cols[c] == 1 SHALL go RELEASE.
REQ-020 RELEASE: SHALL count consecutive cycles with cols == 4'b1111; DEB_CYCLES reached -> SCAN with r advanced mod 4; any low column -> HOLD, counter cleared; no new key is emitted.
REQ-021 Buffer SHALL be one entry; key_valid & key_ready clears it at the clock edge; key SHALL stay stable while key_valid is high and not popped.
REQ-022 key_ready without key_valid SHALL have no effect.
REQ-023 Press-to-key_valid latency SHALL be at most SCAN_DIV*4 + DEB_CYCLES + 1 cycles plus the synchronizer latency (REQ-028).
REQ-024 Counters SHALL be sized to $clog2 of their parameter + 1 and SHALL saturate, never wrap.

Reset
REQ-025 While reset == 0: state = SCAN, r = 0, rows = 4'b1110, key = 4'h0, key_valid = 0, key_held = 0, overrun = 0, all counters and synchronizer flops cleared (synchronizer flops reset to 1).
REQ-026 Reset asserted mid-DEBOUNCE, HOLD or RELEASE SHALL abandon the key with no emission; a buffered code SHALL be lost.
REQ-027 After release, scanning SHALL begin on the first clk edge with row 0 receiving a full SCAN_DIV dwell.

Configuration
REQ-028 With KEYPAD_COL_SYNC_EN defined: cols SHALL pass through a 2-flop synchronizer before all use (2 cycles added latency); without it: cols is sampled directly with 0 added latency, and the module requires cols synchronous to clk.

Verification
REQ-029 Reset low 100 ns then high, cols = 4'b1111 -> rows cycles 1110,1101,1011,0111,1110 every 16 clocks; key_valid stays 0.
REQ-030 cols = 4'b0111 while rows = 4'b1011 held 200 cycles, key_ready = 1 -> one key_valid pulse, key = 4'hB, key_held high until release.
REQ-031 Low glitch on cols lasting 10 cycles during rows = 4'b1110 -> no key_valid; scan resumes on row 0.
REQ-032 key_ready = 0; press key 4'h1 then key 4'h6, full debounce/release each -> key = 4'h1 held with key_valid, overrun single pulse at the second press; then key_ready = 1 -> key_valid drops the next cycle.
REQ-033 cols = 4'b1010 on row 2 -> key = 4'h8 (lowest column wins).
REQ-034 Reset asserted in HOLD with key_valid = 1 -> key_valid = 0, rows = 4'b1110 immediately; with and without KEYPAD_COL_SYNC_EN, latency in REQ-030 differs by exactly 2 cycles.
